// File: rtl/coeff_register_array_if.sv
// Coefficient bank access bus: shared address, write data/strobe, combinational read data.
// write_en is a single-cycle strobe with no ready: a write is taken on every rising edge it is high.
interface coeff_register_array_if #(
   parameter int COEFF_W = 8,
   parameter int ADDR_W  = 7
);
   logic [ADDR_W-1:0]  addr;
   logic [COEFF_W-1:0] coeff_in;
   logic               write_en;
   logic [COEFF_W-1:0] coeff_out;

   modport master (
      output addr,
      output coeff_in,
      output write_en,
      input  coeff_out
   );

   modport slave (
      input  addr,
      input  coeff_in,
      input  write_en,
      output coeff_out
   );
endinterface

// File: rtl/coeff_register_array.sv
// Flop-based FIR coefficient bank: one write per clock, combinational read by address.
// Addresses at or beyond NUM_COEFFS match no entry, so such writes are dropped and reads return 0.
module coeff_register_array #(
   parameter int NUM_COEFFS = 71,
   parameter int COEFF_W    = 8,
   parameter int ADDR_W     = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   coeff_register_array_if.slave bus
);

   logic [COEFF_W-1:0] coeff_q [NUM_COEFFS];
   logic [COEFF_W-1:0] coeff_d [NUM_COEFFS];
   logic [COEFF_W-1:0] rd_data;

   always_comb begin
      for (int i = 0; i < NUM_COEFFS; i++) begin
         coeff_d[i] = coeff_q[i];
         if (bus.write_en && (bus.addr == ADDR_W'(i))) begin
            coeff_d[i] = bus.coeff_in;
         end
      end
   end

   // Decoded one-hot mux; no match (out-of-range address) leaves the default 0.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         if (bus.addr == ADDR_W'(i)) begin
            rd_data = coeff_q[i];
         end
      end
   end

   assign bus.coeff_out = rd_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_COEFFS; i++) begin
            coeff_q[i] <= '0;
         end
      end else begin
         coeff_q <= coeff_d;
      end
   end

endmodule

// File: tb/tb_coeff_register_array.sv
// Directed bench for coeff_register_array: reset, load, hold, out-of-range, read-during-write, reset mid-load.
module tb_coeff_register_array;

   localparam int NUM_COEFFS = 71;
   localparam int COEFF_W    = 8;
   localparam int ADDR_W     = 7;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   coeff_register_array_if #(.COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) bus ();

   coeff_register_array #(
      .NUM_COEFFS (NUM_COEFFS),
      .COEFF_W    (COEFF_W),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic test_reset();
      logic [COEFF_W-1:0] exp;
      rst_n        = 1'b0;
      bus.write_en = 1'b0;
      bus.addr     = '0;
      bus.coeff_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp   = '0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL reset_read addr=%0d got=%h exp=%h", i, bus.coeff_out, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load();
      logic [COEFF_W-1:0] exp;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         @(negedge clk);
         bus.addr     = ADDR_W'(i);
         bus.coeff_in = COEFF_W'(i + 10);
         bus.write_en = 1'b1;
      end
      @(negedge clk);
      bus.write_en = 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         exp      = COEFF_W'(i + 10);
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL load_read addr=%0d got=%h exp=%h", i, bus.coeff_out, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_hold();
      logic [COEFF_W-1:0] exp;
      bus.write_en = 1'b0;
      bus.coeff_in = 8'hFF;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         @(negedge clk);
      end
      for (int i = 0; i < NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         exp      = COEFF_W'(i + 10);
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL hold_read addr=%0d got=%h exp=%h", i, bus.coeff_out, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_out_of_range();
      logic [COEFF_W-1:0] exp;
      logic [ADDR_W-1:0]  oor [2];
      oor[0] = 7'd71;
      oor[1] = 7'd127;
      for (int k = 0; k < 2; k++) begin
         bus.addr     = oor[k];
         bus.coeff_in = 8'hAA;
         bus.write_en = 1'b1;
         @(negedge clk);
      end
      bus.write_en = 1'b0;
      exp          = '0;
      for (int k = 0; k < 2; k++) begin
         bus.addr = oor[k];
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL oor_read addr=%0d got=%h exp=%h", oor[k], bus.coeff_out, exp);
         end
         @(negedge clk);
      end
      for (int i = 0; i < NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         exp      = COEFF_W'(i + 10);
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL oor_untouched addr=%0d got=%h exp=%h", i, bus.coeff_out, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_read_during_write();
      bus.addr     = 7'd5;
      bus.coeff_in = 8'hC3;
      bus.write_en = 1'b1;
      #1;
      n_checks++;
      if (bus.coeff_out !== 8'd15) begin
         n_fail++;
         $display("FAIL rdw_before addr=5 got=%h exp=%h", bus.coeff_out, 8'd15);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.coeff_out !== 8'hC3) begin
         n_fail++;
         $display("FAIL rdw_after addr=5 got=%h exp=%h", bus.coeff_out, 8'hC3);
      end
      @(negedge clk);
      bus.write_en = 1'b0;
      bus.addr     = 7'd4;
      #1;
      n_checks++;
      if (bus.coeff_out !== 8'd14) begin
         n_fail++;
         $display("FAIL rdw_neighbor addr=4 got=%h exp=%h", bus.coeff_out, 8'd14);
      end
      bus.addr = 7'd6;
      #1;
      n_checks++;
      if (bus.coeff_out !== 8'd16) begin
         n_fail++;
         $display("FAIL rdw_neighbor addr=6 got=%h exp=%h", bus.coeff_out, 8'd16);
      end
      bus.addr = 7'd5;
      #1;
      n_checks++;
      if (bus.coeff_out !== 8'hC3) begin
         n_fail++;
         $display("FAIL rdw_hold addr=5 got=%h exp=%h", bus.coeff_out, 8'hC3);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      logic [COEFF_W-1:0] exp;
      bus.addr     = 7'd3;
      bus.coeff_in = 8'h55;
      bus.write_en = 1'b1;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      exp = '0;
      n_checks++;
      if (bus.coeff_out !== exp) begin
         n_fail++;
         $display("FAIL rst_mid_load addr=3 got=%h exp=%h", bus.coeff_out, exp);
      end
      @(negedge clk);
      rst_n        = 1'b1;
      bus.write_en = 1'b0;
      for (int i = 0; i <= NUM_COEFFS; i++) begin
         bus.addr = ADDR_W'(i);
         #1;
         n_checks++;
         if (bus.coeff_out !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_sweep addr=%0d got=%h exp=%h", i, bus.coeff_out, exp);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_load();
      test_hold();
      test_out_of_range();
      test_read_during_write();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
